// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multi-cycle RISC-V control FSM sequencing fetch/decode/exec/mem/wb
// with MemReady wait handling, timeout trap and a retired-instruction counter.
module multicycle_control_unit #(
  parameter int ALU_W    = 3,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [6:0]       Opcode,
  input  logic [2:0]       Funct_Tres,
  input  logic [6:0]       Funct_Siete,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             MemRead,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             WDSrc,
  output logic             ImmReg,
  output logic             ALUSrc,
  output logic             MemToReg,
  output logic [ALU_W-1:0] ALUControl,
  output logic             InstrDone,
  output logic             Fault,
  output logic [1:0]       FaultCode,
  output logic [CNT_W-1:0] Retired
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011,
                         OP_SW = 7'b0100011, OP_LUI = 7'b0110111;
  state_t state_q, state_d;
  logic [6:0] op_q, op_d, f7_q, f7_d;
  logic [2:0] f3_q, f3_d, alu3;
  logic [7:0] wait_q, wait_d;
  logic [1:0] fc_q, fc_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic is_r, is_i, is_lw, is_sw, is_lui, live, dp, timeout, in_alu, f3_ok;
  assign is_r    = op_q == OP_R;
  assign is_i    = op_q == OP_I;
  assign is_lw   = op_q == OP_LW;
  assign is_sw   = op_q == OP_SW;
  assign is_lui  = op_q == OP_LUI;
  assign in_alu  = Opcode == OP_R || Opcode == OP_I;
  assign f3_ok   = Funct_Tres inside {3'b000, 3'b111, 3'b100, 3'b001};
  assign timeout = wait_q == 8'(WAIT_MAX);
  // Only R and I-ALU use the funct3 map; loads/stores/LUI compute with ADD.
  assign alu3 = !(is_r || is_i) ? 3'd0 :
                f3_q == 3'b000  ? {2'b00, is_r && f7_q == 7'b0100000} :
                f3_q == 3'b111  ? 3'd2 :
                f3_q == 3'b100  ? 3'd3 : 3'd4;
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    f3_d    = f3_q;
    f7_d    = f7_q;
    fc_d    = fc_q;
    ret_d   = InstrDone ? ret_q + 1'b1 : ret_q;
    case (state_q)
      FETCH: begin
        if (MemReady) state_d = DECODE;
        else if (timeout) begin
          state_d = TRAP;
          fc_d    = 2'b10;
        end
      end
      DECODE: begin
        op_d = Opcode;
        f3_d = Funct_Tres;
        f7_d = Funct_Siete;
        if (Opcode == OP_LW || Opcode == OP_SW || (in_alu && f3_ok)) state_d = EXEC;
        else if (Opcode == OP_LUI) state_d = WB;
        else begin
          state_d = TRAP;
          fc_d    = 2'b01;
        end
      end
      EXEC: state_d = (is_lw || is_sw) ? MEM : WB;
      MEM: begin
        if (MemReady) state_d = is_sw ? FETCH : WB;
        else if (timeout) begin
          state_d = TRAP;
          fc_d    = 2'b11;
        end
      end
      WB: state_d = FETCH;
      default: ;
    endcase
    wait_d = (state_d != state_q) ? 8'd0 : wait_q + 8'd1;
  end
  always_ff @(posedge CLK) begin
    op_q <= op_d;
    f3_q <= f3_d;
    f7_q <= f7_d;
    if (Reset) begin
      state_q <= FETCH;
      wait_q  <= '0;
      fc_q    <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fc_q    <= fc_d;
      ret_q   <= ret_d;
    end
  end
  // Reset forces every output low combinationally so a pending store is dropped at once.
  assign live       = !Reset;
  assign dp         = live && state_q inside {EXEC, MEM, WB};
  assign PCWrite    = live && state_q == FETCH && MemReady;
  assign IRWrite    = PCWrite;
  assign MemRead    = live && (state_q == FETCH || (state_q == MEM && is_lw));
  assign MemWrite   = live && state_q == MEM && is_sw;
  assign RegWrite   = live && state_q == WB;
  assign ALUControl = dp ? ALU_W'(alu3) : '0;
  assign ALUSrc     = dp && is_r;
  assign ImmReg     = dp && is_sw;
  assign WDSrc      = dp && !is_lui;
  assign MemToReg   = dp && is_lw;
  assign InstrDone  = live && (state_q == WB || (state_q == MEM && is_sw && MemReady));
  assign Fault      = live && state_q == TRAP;
  assign FaultCode  = live ? fc_q : 2'b00;
  assign Retired    = live ? ret_q : '0;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: per-instruction expected-output script derived from the
// instruction semantics, random instruction/wait/reset stimulus, plus literal latency pins.
module tb_multicycle_control_unit;
  localparam int WMAX = 15;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011,
                         OP_SW = 7'b0100011, OP_LUI = 7'b0110111;
  localparam logic [15:0] B_PCW = 16'h8000, B_IRW = 16'h4000, B_MR = 16'h2000, B_RW = 16'h1000,
                          B_MW = 16'h0800, B_WDS = 16'h0400, B_IMM = 16'h0200, B_ALS = 16'h0100,
                          B_M2R = 16'h0080, B_DONE = 16'h0008, B_FLT = 16'h0004;
  logic CLK = 0, Reset = 1, MemReady = 0;
  logic [6:0] Opcode = 0, Funct_Siete = 0;
  logic [2:0] Funct_Tres = 0;
  logic PCWrite, IRWrite, MemRead, RegWrite, MemWrite, WDSrc, ImmReg, ALUSrc, MemToReg;
  logic [2:0] ALUControl;
  logic InstrDone, Fault;
  logic [1:0] FaultCode;
  logic [3:0] Retired;
  int n_chk = 0, n_fail = 0, cyc = 0, abort_at = -1, done_cyc = 0, ret = 0, n;
  logic aborted = 0;
  logic [1:0] trap_code = 0;
  logic [6:0] iop, if7;
  logic [2:0] if3;

  multicycle_control_unit #(.ALU_W(3), .WAIT_MAX(WMAX), .CNT_W(4)) dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Funct_Tres(Funct_Tres),
    .Funct_Siete(Funct_Siete), .MemReady(MemReady), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .MemRead(MemRead), .RegWrite(RegWrite), .MemWrite(MemWrite), .WDSrc(WDSrc),
    .ImmReg(ImmReg), .ALUSrc(ALUSrc), .MemToReg(MemToReg), .ALUControl(ALUControl),
    .InstrDone(InstrDone), .Fault(Fault), .FaultCode(FaultCode), .Retired(Retired));

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare every output at the falling edge, advance.
  task automatic step(input logic [15:0] e, input logic rdy, input logic dec);
    if (cyc == abort_at) aborted = 1;
    Reset = aborted;
    MemReady = rdy;
    Opcode = dec ? iop : 7'($urandom);
    Funct_Tres = dec ? if3 : 3'($urandom);
    Funct_Siete = dec ? if7 : 7'($urandom);
    @(negedge CLK);
    chk("outputs", {PCWrite, IRWrite, MemRead, RegWrite, MemWrite, WDSrc, ImmReg, ALUSrc,
                    MemToReg, ALUControl, InstrDone, Fault, FaultCode}, aborted ? 16'h0 : e);
    chk("retired", Retired, aborted ? 0 : ret);
    @(posedge CLK); #1;
    if (!aborted && (e & B_DONE) != 0) begin
      ret = (ret + 1) & 15;
      done_cyc = cyc + 1;
    end
    cyc++;
  endtask

  // Memory-handshake phase: ready arrives after w wait cycles; more than WMAX waits traps.
  task automatic mphase(input logic [15:0] base, input logic [15:0] rmask, input int w,
                        input logic [1:0] code);
    for (int i = 0; ; i++) begin
      step((i == w) ? base | rmask : base, i == w, 0);
      if (aborted || i == w) return;
      if (i == WMAX) begin
        trap_code = code;
        return;
      end
    end
  endtask

  function automatic logic ok();
    return !aborted && trap_code == 0;
  endfunction

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input int fw, input int mw, input int abort, output int ncyc);
    logic r, i_, lw, sw, lui, ill;
    logic [2:0] alu;
    logic [15:0] ctrl;
    cyc = 0; abort_at = abort; aborted = 0; trap_code = 0; done_cyc = 0;
    iop = op; if3 = f3; if7 = f7;
    r = op == OP_R; i_ = op == OP_I; lw = op == OP_LW; sw = op == OP_SW; lui = op == OP_LUI;
    ill = !(r || i_ || lw || sw || lui) || ((r || i_) && !(f3 inside {3'd0, 3'd7, 3'd4, 3'd1}));
    case (f3)
      3'd0: alu = (r && f7 == 7'b0100000) ? 3'd1 : 3'd0;
      3'd7: alu = 3'd2;
      3'd4: alu = 3'd3;
      default: alu = 3'd4;
    endcase
    if (!(r || i_)) alu = 3'd0;
    ctrl = (lui ? 16'h0 : B_WDS) | (sw ? B_IMM : 16'h0) | (r ? B_ALS : 16'h0) |
           (lw ? B_M2R : 16'h0) | {9'b0, alu, 4'b0};
    mphase(B_MR, B_PCW | B_IRW, fw, 2'b10);
    if (ok()) begin
      step(16'h0, 1'($urandom), 1);
      if (ill) trap_code = 2'b01;
    end
    if (ok() && !lui) step(ctrl, 1'($urandom), 0);
    if (ok() && (lw || sw)) mphase(ctrl | (lw ? B_MR : B_MW), sw ? B_DONE : 16'h0, mw, 2'b11);
    if (ok() && !sw) step(ctrl | B_RW | B_DONE, 1'($urandom), 0);
    ncyc = done_cyc;
    if (!aborted && trap_code != 0) begin
      repeat (3) step(B_FLT | {14'b0, trap_code}, 1'($urandom), 0);
      abort_at = cyc;
      step(16'h0, 1'($urandom), 0);
    end
    if (aborted) ret = 0;
    Reset = 0;
  endtask

  initial begin
    int fw, mw, ab, pick;
    logic [6:0] op, f7;
    aborted = 1; abort_at = -1;
    repeat (2) step(16'h0, 1'($urandom), 0);
    aborted = 0; ret = 0;
    run_instr(OP_R, 3'd0, 7'h00, 0, 0, -1, n); chk("lat_add", n, 4);
    run_instr(OP_R, 3'd0, 7'h20, 0, 0, -1, n); chk("lat_sub", n, 4);
    chk("retired_after_2", Retired, 2);
    run_instr(OP_SW, 3'd2, 7'h00, 0, 3, -1, n); chk("lat_sw_wait3", n, 7);
    run_instr(OP_LW, 3'd2, 7'h00, 0, 0, -1, n); chk("lat_lw", n, 5);
    run_instr(OP_LUI, 3'd5, 7'h11, 0, 0, -1, n); chk("lat_lui", n, 3);
    run_instr(OP_I, 3'd0, 7'h20, 0, 0, -1, n); chk("lat_addi", n, 4);
    run_instr(7'h7F, 3'd0, 7'h00, 0, 0, -1, n); chk("illegal_code", trap_code, 1);
    run_instr(OP_R, 3'd2, 7'h00, 0, 0, -1, n); chk("bad_funct3_code", trap_code, 1);
    run_instr(OP_R, 3'd4, 7'h00, 16, 0, -1, n); chk("fetch_timeout_code", trap_code, 2);
    run_instr(OP_R, 3'd7, 7'h00, 15, 0, -1, n); chk("lat_fetch_wait15", n, 19);
    run_instr(OP_LW, 3'd2, 7'h00, 0, 16, -1, n); chk("data_timeout_code", trap_code, 3);
    run_instr(OP_LW, 3'd2, 7'h00, 1, 15, -1, n); chk("lat_lw_wait16", n, 21);
    run_instr(OP_SW, 3'd2, 7'h00, 0, 5, 4, n); chk("sw_abort_flag", aborted, 1);
    run_instr(OP_R, 3'd1, 7'h00, 0, 0, -1, n); chk("lat_after_abort", n, 4);
    for (int k = 0; k < 400; k++) begin
      pick = $urandom_range(0, 6);
      op = pick == 0 ? OP_R : pick == 1 ? OP_I : pick == 2 ? OP_LW : pick == 3 ? OP_SW :
           pick == 4 ? OP_LUI : pick == 5 ? OP_R : 7'($urandom);
      f7 = $urandom_range(0, 2) == 0 ? 7'($urandom) : ($urandom_range(0, 1) ? 7'h20 : 7'h00);
      fw = $urandom_range(0, 24) == 0 ? $urandom_range(14, 16) : $urandom_range(0, 2);
      mw = $urandom_range(0, 24) == 0 ? $urandom_range(14, 16) : $urandom_range(0, 3);
      ab = $urandom_range(0, 19) == 0 ? $urandom_range(0, 7) : -1;
      run_instr(op, 3'($urandom), f7, fw, mw, ab, n);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
